br_resolve_queue: RTL and testbench

- In-order queue of in-flight predicted branches between fetch and the branch predictor's update port.
- Fetch allocates one entry per decoded branch, carrying its prediction. Execute resolves entries out of order by tag.
- A mispredict raises a one-cycle redirect and squashes all younger entries.
- Resolved entries retire in order from the head and drive the predictor's ex_* training interface, so BTB/direction tables are trained only on non-squashed branches.

---
 rtl/br_resolve_queue_if.sv | 50 +++++
 rtl/br_resolve_queue.sv | 171 +++++++++++++++++
 tb/tb_br_resolve_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_queue_if.sv
// Purpose: bundles the fetch-allocate, execute-resolve, redirect and predictor-training
//          signals of br_resolve_queue so that one port carries the whole bus.
// Modports:
//   master - fetch/execute side: drives alloc_* and res_*, observes status/redirect/ex_*
//   slave  - the queue itself
// Signals:
//   alloc_valid_i/pc_i/is_cond_i/pred_taken_i/pred_target_i : allocation request + prediction
//   alloc_ready_o, alloc_tag_o                               : space available, granted tag
//   res_valid_i/tag_i/taken_i/target_i                       : out-of-order resolution
//   mispred_o, redirect_pc_o                                 : one-cycle redirect pulse
//   ex_is_br_o/is_cond_o/is_taken_o/pc_o/br_target_o         : in-order predictor training
//   count_o                                                  : occupied entries
interface br_resolve_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 3
);
    logic             alloc_valid_i;
    logic [63:0]      alloc_pc_i;
    logic             alloc_is_cond_i;
    logic             alloc_pred_taken_i;
    logic [63:0]      alloc_pred_target_i;
    logic             alloc_ready_o;
    logic [TAG_W-1:0] alloc_tag_o;
    logic             res_valid_i;
    logic [TAG_W-1:0] res_tag_i;
    logic             res_taken_i;
    logic [63:0]      res_target_i;
    logic             mispred_o;
    logic [63:0]      redirect_pc_o;
    logic             ex_is_br_o;
    logic             ex_is_cond_o;
    logic             ex_is_taken_o;
    logic [63:0]      ex_pc_o;
    logic [63:0]      ex_br_target_o;
    logic [TAG_W:0]   count_o;

    modport master (
        output alloc_valid_i, alloc_pc_i, alloc_is_cond_i, alloc_pred_taken_i,
               alloc_pred_target_i, res_valid_i, res_tag_i, res_taken_i, res_target_i,
        input  alloc_ready_o, alloc_tag_o, mispred_o, redirect_pc_o, ex_is_br_o,
               ex_is_cond_o, ex_is_taken_o, ex_pc_o, ex_br_target_o, count_o
    );

    modport slave (
        input  alloc_valid_i, alloc_pc_i, alloc_is_cond_i, alloc_pred_taken_i,
               alloc_pred_target_i, res_valid_i, res_tag_i, res_taken_i, res_target_i,
        output alloc_ready_o, alloc_tag_o, mispred_o, redirect_pc_o, ex_is_br_o,
               ex_is_cond_o, ex_is_taken_o, ex_pc_o, ex_br_target_o, count_o
    );
endinterface

// File: rtl/br_resolve_queue.sv
// Purpose: in-order queue of in-flight predicted branches. Fetch allocates at the tail,
//          execute resolves by tag in any order, a mispredict pulses a redirect and squashes
//          all younger entries, and resolved entries retire in order from the head to train
//          the branch predictor through the ex_* outputs.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - br_resolve_queue_if.slave (allocate / resolve / redirect / train / count)
module br_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 3
) (
    input logic               clk,
    input logic               rst,
    br_resolve_queue_if.slave bus
);

    localparam int unsigned CW = TAG_W + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    // Pointers and occupancy
    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [CW-1:0]    r_count;

    // Per-entry control (reset) and payload (not reset; only read while valid)
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_resolved;
    logic [63:0]      r_pc          [DEPTH];
    logic             r_is_cond     [DEPTH];
    logic             r_pred_taken  [DEPTH];
    logic [63:0]      r_pred_target [DEPTH];
    logic             r_act_taken   [DEPTH];
    logic [63:0]      r_act_target  [DEPTH];

    // Registered outputs
    logic             r_mispred;
    logic [63:0]      r_redirect_pc;
    logic             r_ex_is_br;
    logic             r_ex_is_cond;
    logic             r_ex_is_taken;
    logic [63:0]      r_ex_pc;
    logic [63:0]      r_ex_br_target;

    logic             w_alloc_ready;
    logic             w_alloc;
    logic             w_res_hit;
    logic             w_mispred;
    logic             w_retire;
    logic [TAG_W-1:0] w_res_off;
    logic [63:0]      w_redirect_pc;
    logic [DEPTH-1:0] w_flush;
    logic [DEPTH-1:0] w_valid_d;
    logic [DEPTH-1:0] w_resolved_d;
    logic [CW-1:0]    w_count_d;
    logic [TAG_W-1:0] w_tail_d;

    // Ready depends only on the registered count: a full queue never sees a same-cycle
    // retire freeing a slot.
    assign w_alloc_ready = (r_count < FullCnt);

    assign w_res_hit = bus.res_valid_i && r_valid[bus.res_tag_i] && !r_resolved[bus.res_tag_i];
    assign w_mispred = w_res_hit &&
                       ((r_pred_taken[bus.res_tag_i] != bus.res_taken_i) ||
                        (bus.res_taken_i && (r_pred_target[bus.res_tag_i] != bus.res_target_i)));
    assign w_retire  = r_valid[r_head] && r_resolved[r_head];
    // Flush wins over a same-cycle allocation.
    assign w_alloc   = bus.alloc_valid_i && w_alloc_ready && !w_mispred;

    // Age of the resolving entry relative to the head (0 = oldest).
    assign w_res_off = bus.res_tag_i - r_head;

    assign w_redirect_pc = bus.res_taken_i ? bus.res_target_i
                                           : (r_pc[bus.res_tag_i] + 64'd4);

    always_comb begin
        w_flush = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Younger than the mispredicting entry = larger age from head.
            if (w_mispred && ((TAG_W'(i) - r_head) > w_res_off)) begin
                w_flush[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_d    = r_valid & ~w_flush;
        w_resolved_d = r_resolved;
        if (w_res_hit) begin
            w_resolved_d[bus.res_tag_i] = 1'b1;
        end
        if (w_retire) begin
            w_valid_d[r_head]    = 1'b0;
            w_resolved_d[r_head] = 1'b0;
        end
        if (w_alloc) begin
            w_valid_d[r_tail]    = 1'b1;
            w_resolved_d[r_tail] = 1'b0;
        end
    end

    always_comb begin
        w_tail_d  = r_tail;
        w_count_d = r_count + CW'(w_alloc) - CW'(w_retire);
        if (w_mispred) begin
            w_tail_d  = bus.res_tag_i + TAG_W'(1);
            w_count_d = CW'(w_res_off) + CW'(1) - CW'(w_retire);
        end else if (w_alloc) begin
            w_tail_d  = r_tail + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_valid        <= '0;
            r_resolved     <= '0;
            r_mispred      <= 1'b0;
            r_redirect_pc  <= '0;
            r_ex_is_br     <= 1'b0;
            r_ex_is_cond   <= 1'b0;
            r_ex_is_taken  <= 1'b0;
            r_ex_pc        <= '0;
            r_ex_br_target <= '0;
        end else begin
            r_head     <= w_retire ? r_head + TAG_W'(1) : r_head;
            r_tail     <= w_tail_d;
            r_count    <= w_count_d;
            r_valid    <= w_valid_d;
            r_resolved <= w_resolved_d;
            r_mispred  <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= w_redirect_pc;
            end
            r_ex_is_br <= w_retire;
            if (w_retire) begin
                r_ex_is_cond   <= r_is_cond[r_head];
                r_ex_is_taken  <= r_act_taken[r_head];
                r_ex_pc        <= r_pc[r_head];
                r_ex_br_target <= r_act_target[r_head];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_pc[r_tail]          <= bus.alloc_pc_i;
            r_is_cond[r_tail]     <= bus.alloc_is_cond_i;
            r_pred_taken[r_tail]  <= bus.alloc_pred_taken_i;
            r_pred_target[r_tail] <= bus.alloc_pred_target_i;
        end
        if (w_res_hit) begin
            r_act_taken[bus.res_tag_i]  <= bus.res_taken_i;
            r_act_target[bus.res_tag_i] <= bus.res_target_i;
        end
    end

    assign bus.alloc_ready_o  = w_alloc_ready;
    assign bus.alloc_tag_o    = r_tail;
    assign bus.mispred_o      = r_mispred;
    assign bus.redirect_pc_o  = r_redirect_pc;
    assign bus.ex_is_br_o     = r_ex_is_br;
    assign bus.ex_is_cond_o   = r_ex_is_cond;
    assign bus.ex_is_taken_o  = r_ex_is_taken;
    assign bus.ex_pc_o        = r_ex_pc;
    assign bus.ex_br_target_o = r_ex_br_target;
    assign bus.count_o        = r_count;

endmodule

// File: tb/tb_br_resolve_queue.sv
// Purpose: self-checking bench for br_resolve_queue. Directed scenarios check fixed values;
//          a randomized run is checked against a queue-of-structs reference model.
module tb_br_resolve_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    br_resolve_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    br_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: oldest entry at index 0.
    typedef struct {
        logic [2:0]  tag;
        logic [63:0] pc;
        logic        is_cond;
        logic        pred_taken;
        logic [63:0] pred_target;
        logic        resolved;
    } ent_t;

    ent_t        mq[$];
    int          m_tail;
    logic        e_mispred;
    logic [63:0] e_redirect;
    logic        e_ex_br;
    logic        e_ex_cond;
    logic        e_ex_taken;
    logic [63:0] e_ex_pc;
    logic [63:0] e_ex_tgt;
    logic        m_act_taken [DEPTH];
    logic [63:0] m_act_tgt   [DEPTH];

    task automatic model_clear();
        mq.delete();
        m_tail     = 0;
        e_mispred  = 0;
        e_redirect = '0;
        e_ex_br    = 0;
        e_ex_cond  = 0;
        e_ex_taken = 0;
        e_ex_pc    = '0;
        e_ex_tgt   = '0;
    endtask

    // Predicts what the coming clock edge does, from the rules of the queue.
    task automatic model_step(input logic av, input logic [63:0] apc, input logic acond,
                              input logic apt, input logic [63:0] aptgt, input logic rv,
                              input logic [2:0] rtag, input logic rtk, input logic [63:0] rtgt);
        bit   retire;
        bit   accept;
        bit   mp;
        int   k;
        ent_t e;
        retire = (mq.size() > 0) && mq[0].resolved;
        accept = av && (mq.size() < DEPTH);
        mp     = 0;
        k      = -1;
        if (rv) begin
            foreach (mq[i]) if (mq[i].tag == rtag && !mq[i].resolved) k = i;
        end
        e_ex_br = retire;
        if (retire) begin
            e_ex_cond  = mq[0].is_cond;
            e_ex_pc    = mq[0].pc;
            e_ex_taken = m_act_taken[mq[0].tag];
            e_ex_tgt   = m_act_tgt[mq[0].tag];
        end
        if (k >= 0) begin
            e = mq[k];
            e.resolved = 1;
            mq[k] = e;
            m_act_taken[rtag] = rtk;
            m_act_tgt[rtag]   = rtgt;
            mp = (e.pred_taken != rtk) || (rtk && e.pred_target != rtgt);
            if (mp) begin
                e_redirect = rtk ? rtgt : e.pc + 64'd4;
                while (mq.size() > k + 1) void'(mq.pop_back());
                m_tail = (int'(rtag) + 1) % DEPTH;
            end
        end
        e_mispred = mp;
        if (retire) void'(mq.pop_front());
        if (accept && !mp) begin
            e.tag = 3'(m_tail);
            e.pc = apc;
            e.is_cond = acond;
            e.pred_taken = apt;
            e.pred_target = aptgt;
            e.resolved = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    // Called at a negedge: drives inputs, advances the model, returns at the next negedge.
    task automatic drive_cycle(input logic av, input logic [63:0] apc, input logic acond,
                               input logic apt, input logic [63:0] aptgt, input logic rv,
                               input logic [2:0] rtag, input logic rtk, input logic [63:0] rtgt);
        bus.alloc_valid_i       = av;
        bus.alloc_pc_i          = apc;
        bus.alloc_is_cond_i     = acond;
        bus.alloc_pred_taken_i  = apt;
        bus.alloc_pred_target_i = aptgt;
        bus.res_valid_i         = rv;
        bus.res_tag_i           = rtag;
        bus.res_taken_i         = rtk;
        bus.res_target_i        = rtgt;
        model_step(av, apc, acond, apt, aptgt, rv, rtag, rtk, rtgt);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alloc(input logic [63:0] pc, input logic pt, input logic [63:0] ptgt);
        drive_cycle(1, pc, 1, pt, ptgt, 0, 3'd0, 0, 64'd0);
    endtask

    task automatic resolve(input logic [2:0] tag, input logic tk, input logic [63:0] tgt);
        drive_cycle(0, 64'd0, 0, 0, 64'd0, 1, tag, tk, tgt);
    endtask

    task automatic idle();
        drive_cycle(0, 64'd0, 0, 0, 64'd0, 0, 3'd0, 0, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.alloc_valid_i = 0;
        bus.res_valid_i   = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.count_o !== 4'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d exp 0", bus.count_o); end
        n_checks++; if (bus.alloc_ready_o !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b exp 1", bus.alloc_ready_o); end
        n_checks++; if (bus.alloc_tag_o !== 3'd0) begin n_fail++;
            $display("FAIL reset_tag: got %0d exp 0", bus.alloc_tag_o); end
        n_checks++; if ({bus.mispred_o, bus.ex_is_br_o, bus.ex_is_cond_o, bus.ex_is_taken_o}
                        !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b exp 0000",
                     {bus.mispred_o, bus.ex_is_br_o, bus.ex_is_cond_o, bus.ex_is_taken_o}); end
        n_checks++; if ({bus.redirect_pc_o, bus.ex_pc_o, bus.ex_br_target_o} !== 192'd0) begin
            n_fail++; $display("FAIL reset_buses: got %h %h %h exp 0", bus.redirect_pc_o,
                               bus.ex_pc_o, bus.ex_br_target_o); end
    endtask

    task automatic test_basic();
        do_reset();
        alloc(64'h1000, 0, 64'h0);
        n_checks++; if (bus.count_o !== 4'd1) begin n_fail++;
            $display("FAIL basic_count1: got %0d exp 1", bus.count_o); end
        resolve(3'd0, 0, 64'h0);
        n_checks++; if (bus.mispred_o !== 1'b0 || bus.ex_is_br_o !== 1'b0) begin n_fail++;
            $display("FAIL basic_noresp: mispred %b ex_is_br %b exp 0 0",
                     bus.mispred_o, bus.ex_is_br_o); end
        idle();
        n_checks++; if (bus.ex_is_br_o !== 1'b1 || bus.ex_pc_o !== 64'h1000 ||
                        bus.ex_is_taken_o !== 1'b0 || bus.ex_is_cond_o !== 1'b1) begin n_fail++;
            $display("FAIL basic_retire: is_br %b pc %h taken %b cond %b exp 1 1000 0 1",
                     bus.ex_is_br_o, bus.ex_pc_o, bus.ex_is_taken_o, bus.ex_is_cond_o); end
        n_checks++; if (bus.count_o !== 4'd0) begin n_fail++;
            $display("FAIL basic_count0: got %0d exp 0", bus.count_o); end
        idle();
        n_checks++; if (bus.ex_is_br_o !== 1'b0 || bus.ex_pc_o !== 64'h1000) begin n_fail++;
            $display("FAIL basic_hold: is_br %b pc %h exp 0 1000", bus.ex_is_br_o,
                     bus.ex_pc_o); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (bus.alloc_tag_o !== 3'(i)) begin n_fail++;
                $display("FAIL fill_tag: got %0d exp %0d", bus.alloc_tag_o, i); end
            alloc(64'h100 * 64'(i), 0, 64'h0);
        end
        n_checks++; if (bus.count_o !== 4'd8 || bus.alloc_ready_o !== 1'b0) begin n_fail++;
            $display("FAIL fill_full: count %0d ready %b exp 8 0", bus.count_o,
                     bus.alloc_ready_o); end
        alloc(64'hDEAD, 0, 64'h0);
        n_checks++; if (bus.count_o !== 4'd8) begin n_fail++;
            $display("FAIL fill_refuse: count %0d exp 8", bus.count_o); end
        resolve(3'd0, 0, 64'h0);
        // Head retires this cycle but the queue is still full: allocation refused.
        alloc(64'hBEEF, 0, 64'h0);
        n_checks++; if (bus.count_o !== 4'd7 || bus.alloc_ready_o !== 1'b1 ||
                        bus.ex_is_br_o !== 1'b1) begin n_fail++;
            $display("FAIL fill_retire: count %0d ready %b is_br %b exp 7 1 1",
                     bus.count_o, bus.alloc_ready_o, bus.ex_is_br_o); end
        n_checks++; if (bus.alloc_tag_o !== 3'd0) begin n_fail++;
            $display("FAIL fill_wraptag: got %0d exp 0", bus.alloc_tag_o); end
        alloc(64'hC000, 0, 64'h0);
        n_checks++; if (bus.count_o !== 4'd8 || bus.alloc_tag_o !== 3'd1) begin n_fail++;
            $display("FAIL fill_wrapalloc: count %0d tag %0d exp 8 1", bus.count_o,
                     bus.alloc_tag_o); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(64'h1000, 0, 64'h0);
        alloc(64'h1100, 1, 64'h2000);
        alloc(64'h1200, 0, 64'h0);
        // Mispredict with a simultaneous allocation request that must be dropped.
        drive_cycle(1, 64'h9999, 1, 0, 64'h0, 1, 3'd1, 1, 64'h2400);
        n_checks++; if (bus.mispred_o !== 1'b1 || bus.redirect_pc_o !== 64'h2400) begin
            n_fail++; $display("FAIL mp_redirect: mispred %b pc %h exp 1 2400",
                               bus.mispred_o, bus.redirect_pc_o); end
        n_checks++; if (bus.count_o !== 4'd2 || bus.alloc_tag_o !== 3'd2) begin n_fail++;
            $display("FAIL mp_flush: count %0d tag %0d exp 2 2", bus.count_o,
                     bus.alloc_tag_o); end
        resolve(3'd2, 1, 64'h7777);
        n_checks++; if (bus.mispred_o !== 1'b0 || bus.count_o !== 4'd2) begin n_fail++;
            $display("FAIL mp_pulse_squashed: mispred %b count %0d exp 0 2", bus.mispred_o,
                     bus.count_o); end
    endtask

    task automatic test_redirect_nt();
        do_reset();
        alloc(64'h3000, 1, 64'h5000);
        resolve(3'd0, 0, 64'h0);
        n_checks++; if (bus.mispred_o !== 1'b1 || bus.redirect_pc_o !== 64'h3004) begin
            n_fail++; $display("FAIL nt_redirect: mispred %b pc %h exp 1 3004",
                               bus.mispred_o, bus.redirect_pc_o); end
        idle();
        n_checks++; if (bus.mispred_o !== 1'b0 || bus.ex_is_br_o !== 1'b1 ||
                        bus.ex_is_taken_o !== 1'b0 || bus.ex_pc_o !== 64'h3000) begin n_fail++;
            $display("FAIL nt_retire: mispred %b is_br %b taken %b pc %h exp 0 1 0 3000",
                     bus.mispred_o, bus.ex_is_br_o, bus.ex_is_taken_o, bus.ex_pc_o); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) alloc(64'h400 + 64'(4 * i), 0, 64'h0);
        for (int i = 2; i >= 0; i--) begin
            resolve(3'(i), 0, 64'h0);
            n_checks++; if (bus.mispred_o !== 1'b0 || bus.ex_is_br_o !== 1'b0) begin n_fail++;
                $display("FAIL ooo_quiet: mispred %b is_br %b exp 0 0", bus.mispred_o,
                         bus.ex_is_br_o); end
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_checks++; if (bus.ex_is_br_o !== 1'b1 || bus.ex_pc_o !== 64'h400 + 64'(4 * i))
            begin n_fail++; $display("FAIL ooo_order: is_br %b pc %h exp 1 %h",
                                     bus.ex_is_br_o, bus.ex_pc_o, 64'h400 + 64'(4 * i)); end
        end
        idle();
        n_checks++; if (bus.ex_is_br_o !== 1'b0 || bus.count_o !== 4'd0) begin n_fail++;
            $display("FAIL ooo_done: is_br %b count %0d exp 0 0", bus.ex_is_br_o,
                     bus.count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) alloc(64'h500 + 64'(8 * i), 0, 64'h0);
        resolve(3'd0, 0, 64'h0);
        resolve(3'd3, 1, 64'h6000);
        n_checks++; if (bus.mispred_o !== 1'b1 || bus.count_o !== 4'd3) begin n_fail++;
            $display("FAIL mid_pre: mispred %b count %0d exp 1 3", bus.mispred_o,
                     bus.count_o); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.count_o !== 4'd0 || bus.mispred_o !== 1'b0 ||
                        bus.ex_is_br_o !== 1'b0 || bus.ex_pc_o !== 64'd0 ||
                        bus.redirect_pc_o !== 64'd0 || bus.alloc_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_async: count %0d mispred %b is_br %b pc %h rpc %h",
                               bus.count_o, bus.mispred_o, bus.ex_is_br_o, bus.ex_pc_o,
                               bus.redirect_pc_o); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            n_checks++; if (bus.mispred_o !== 1'b0 || bus.ex_is_br_o !== 1'b0 ||
                            bus.count_o !== 4'd0) begin n_fail++;
                $display("FAIL mid_after: mispred %b is_br %b count %0d exp 0 0 0",
                         bus.mispred_o, bus.ex_is_br_o, bus.count_o); end
        end
    endtask

    task automatic test_random();
        logic        av, acond, apt, rv, rtk;
        logic [63:0] apc, aptgt, rtgt;
        logic [2:0]  rtag;
        int          idx;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            av    = ($urandom_range(0, 9) < 6);
            apc   = {32'($urandom), 32'($urandom)};
            acond = 1'($urandom);
            apt   = 1'($urandom);
            aptgt = $urandom_range(0, 1) ? 64'h8000 : 64'h9000;
            rv    = ($urandom_range(0, 1) == 1);
            rtk   = 1'($urandom);
            rtgt  = $urandom_range(0, 1) ? 64'h8000 : 64'h9000;
            rtag  = 3'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                idx  = $urandom_range(0, mq.size() - 1);
                rtag = mq[idx].tag;
                if ($urandom_range(0, 1) == 1) rtgt = mq[idx].pred_target;
            end
            drive_cycle(av, apc, acond, apt, aptgt, rv, rtag, rtk, rtgt);
            n_checks++; if (bus.count_o !== 4'(mq.size()) ||
                            bus.alloc_ready_o !== (mq.size() < DEPTH) ||
                            bus.alloc_tag_o !== 3'(m_tail)) begin n_fail++;
                $display("FAIL rnd_state cyc %0d: count %0d ready %b tag %0d exp %0d %b %0d",
                         cyc, bus.count_o, bus.alloc_ready_o, bus.alloc_tag_o, mq.size(),
                         mq.size() < DEPTH, m_tail); end
            n_checks++; if (bus.mispred_o !== e_mispred || bus.redirect_pc_o !== e_redirect)
            begin n_fail++; $display("FAIL rnd_redirect cyc %0d: %b %h exp %b %h", cyc,
                                     bus.mispred_o, bus.redirect_pc_o, e_mispred,
                                     e_redirect); end
            n_checks++; if (bus.ex_is_br_o !== e_ex_br || bus.ex_is_cond_o !== e_ex_cond ||
                            bus.ex_is_taken_o !== e_ex_taken || bus.ex_pc_o !== e_ex_pc ||
                            bus.ex_br_target_o !== e_ex_tgt) begin n_fail++;
                $display("FAIL rnd_train cyc %0d: %b %b %b %h %h exp %b %b %b %h %h", cyc,
                         bus.ex_is_br_o, bus.ex_is_cond_o, bus.ex_is_taken_o, bus.ex_pc_o,
                         bus.ex_br_target_o, e_ex_br, e_ex_cond, e_ex_taken, e_ex_pc,
                         e_ex_tgt); end
        end
    endtask

    initial begin
        bus.alloc_valid_i       = 0;
        bus.alloc_pc_i          = '0;
        bus.alloc_is_cond_i     = 0;
        bus.alloc_pred_taken_i  = 0;
        bus.alloc_pred_target_i = '0;
        bus.res_valid_i         = 0;
        bus.res_tag_i           = '0;
        bus.res_taken_i         = 0;
        bus.res_target_i        = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill_wrap();
        test_mispredict();
        test_redirect_nt();
        test_out_of_order();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
